syn_ram_param: RTL
==================

# syn_ram_param

Parametrised synchronous simple-dual-port RAM: one write port and one read port on a single clock, with configurable data width and depth, per-byte write enables and an optional output register stage. A built-in clear engine zeroes every location after reset or on request, and a read-valid strobe marks when data is ready. It replaces the fixed 16-bit × 256 RAM wherever a design needs a different geometry, deterministic power-up contents or partial-word writes.

## Interface
- `DATA_W`, 16: word width in bits; must be a multiple of 8.
- `ADDR_W`, 8: address width in bits.
- `DEPTH`, 2**ADDR_W: number of words; 2 ≤ DEPTH ≤ 2**ADDR_W.
- `OUT_REG`, 0: 0 gives read latency 1; 1 adds an output register, giving read latency 2.
- `clk`  in  1  clock; all logic samples on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `we`  in  1  write request.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  DATA_W  write data.
- `wr_be`  in  DATA_W/8  byte enables; bit i gates `wr_data[8i+7:8i]`.
- `re`  in  1  read request.
- `rd_addr`  in  ADDR_W  read address.
- `clr`  in  1  start a clear sweep; single-cycle pulse.
- `rd_data`  out  DATA_W  read data.
- `rd_valid`  out  1  `rd_data` holds the result of an accepted read.
- `busy`  out  1  clear sweep in progress.

## Operation
- FSM states: CLEAR and IDLE. `rst` forces CLEAR with clear pointer = 0.
- **CLEAR state**
  - Each cycle, write 0 to mem[ptr] and increment ptr.
  - On the cycle ptr = DEPTH-1 is written, go to IDLE.
  - A sweep takes exactly DEPTH cycles.
- **IDLE state**
  - Write: `we`=1 and `wr_addr` < DEPTH → update the bytes selected by `wr_be`. Unselected bytes keep their value. `wr_be`=0 is a no-op.
  - Read: `re`=1 and `rd_addr` < DEPTH → read is accepted.
  - Out-of-range addresses: writes are dropped. Reads are accepted and return 0.
  - Write and read in the same cycle at different addresses: both complete independently.
  - Read-during-write at the same address: returns the old word (read-first).
- **`clr` handling**
  - `clr`=1 in IDLE → go to CLEAR. `we` and `re` in that same cycle are dropped.
  - `clr` during CLEAR is ignored; the sweep is not restarted.
- **While `busy`=1**
  - `we` and `re` are dropped silently. There is no stall or back-pressure; the requester must check `busy`.
  - Reads already in the pipeline before CLEAR was entered still complete with pre-clear data.
- **`rd_data` between reads**
  - Holds its last value while `rd_valid`=0.
  - 0 after reset until the first accepted read.

## Timing
- **Reset values** (applied on the first rising edge with `rst`=1, held while it stays high): `rd_data`=0, `rd_valid`=0, `busy`=1.
- **After reset**
  - `rst` deasserted at edge T → `busy` falls after edge T+DEPTH.
  - The first write or read is accepted at edge T+DEPTH+1.
- **`clr`**: `clr` sampled at edge C → `busy`=1 after edge C, and falls after edge C+DEPTH.
- **Reset mid-sweep**: the sweep restarts from address 0; full DEPTH cycles again.
- **Read latency**
  - Read accepted at edge R → `rd_data` is valid with `rd_valid`=1 after edge R+1 (OUT_REG=0) or R+2 (OUT_REG=1).
  - `rd_valid` is a one-cycle pulse per accepted read.
  - Back-to-back reads give back-to-back valid pulses; throughput is one read per cycle.
- **Write visibility**: a write at edge W is visible to a read accepted at edge W+1 or later.
- **Reset mid-read**: in-flight reads are discarded; `rd_valid` stays 0.

## Configuration
- Macro: `SYN_RAM_PARAM_BYPASS_EN`.
- **Defined**: read-during-write at the same address returns the new word, i.e. the old word with the enabled bytes of `wr_data` merged in (write-first forwarding). Same latency.
- **Undefined**: read-first behaviour as in Operation. No forwarding logic is built.

## Test plan
Bench configuration unless stated: DATA_W=16, ADDR_W=4, DEPTH=16.
- **Reset and clear sweep**: pulse `rst`, release → `busy`=1 for 16 cycles, then 0. Reads of addresses 0..15 all return 0x0000. `rd_valid`=0 throughout the sweep.
- **Byte enables**
  - Write 0xAABB to addr 4 with `wr_be`=11, then 0x1234 to addr 4 with `wr_be`=01.
  - Read addr 4 → 0xAA34, `rd_valid` 1 cycle after `re` (OUT_REG=0) or 2 cycles after (OUT_REG=1).
- **Read-during-write**
  - Addr 7 holds 0x00DD; write 0x55AA to addr 7 with `re`=1 at addr 7 in the same cycle.
  - Without the macro → 0x00DD. With `SYN_RAM_PARAM_BYPASS_EN` → 0x55AA.
  - The next read of addr 7 → 0x55AA in both builds.
- **`clr` with traffic**
  - Fill addrs 0..15 with 0x1000+addr; pulse `clr` together with a write of 0xFFFF to addr 3.
  - → the write is dropped, `busy`=1 for 16 cycles, and all reads afterwards return 0.
- **Reset mid-sweep**: assert `rst` at sweep cycle 9 → `busy` stays 1 for a further 16 cycles after `rst` is released. A `re` issued during the sweep produces no `rd_valid`.
- **Range and throughput** (DEPTH=12)
  - A write to addr 13 is dropped; a read of addr 13 → 0x0000 with `rd_valid`=1.
  - 12 back-to-back reads → 12 consecutive `rd_valid` pulses carrying the correct data.

Source files
------------

// File: rtl/syn_ram_param.sv
// ---------------------------------------------------------------------------
// syn_ram_param
//
// Parametrised synchronous simple-dual-port RAM. There is one write port and
// one read port, both on a single clock. The block provides per-byte write
// enables, an optional output register and a built-in clear engine. The clear
// engine zeroes every word after reset, or when clr is pulsed.
//
// Parameters
//   DATA_W   word width in bits (multiple of 8)
//   ADDR_W   address width in bits
//   DEPTH    number of words, 2 <= DEPTH <= 2**ADDR_W
//   OUT_REG  0: read latency 1, 1: extra output register, read latency 2
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset (restarts the clear sweep)
//   we        in   write request
//   wr_addr   in   write address
//   wr_data   in   write data
//   wr_be     in   byte enables, bit i gates wr_data[8i+7:8i]
//   re        in   read request
//   rd_addr   in   read address
//   clr       in   single-cycle pulse that starts a clear sweep
//   rd_data   out  read data. It holds its value between reads and is 0
//                  after reset.
//   rd_valid  out  one-cycle pulse per accepted read
//   busy      out  clear sweep in progress; we/re are dropped while high
//
// Build option
//   SYN_RAM_PARAM_BYPASS_EN  when defined, a read and a write to the same
//                            address in the same cycle return the merged
//                            new word (write-first). When undefined, they
//                            return the old word (read-first).
// ---------------------------------------------------------------------------
module syn_ram_param #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 2 ** ADDR_W,
  parameter int OUT_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     rd_addr,
  input  logic                  clr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  busy
);

  localparam int BE_W = DATA_W / 8;

  // Range checks use one extra bit so that DEPTH == 2**ADDR_W fits.
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   w_ptr_nxt;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_idle_go;
  logic                w_wr_in;
  logic                w_rd_in;
  logic                w_wr_ok;
  logic                w_rd_ok;
  logic                w_clr_wr;
  logic [DATA_W-1:0]   w_rd_word;

  logic                r_vld_p0;
  logic [DATA_W-1:0]   r_rd_data_p0;

  // Replace the bytes of old_w selected by be with the matching bytes of new_w.
  function automatic logic [DATA_W-1:0] f_merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  // A clr pulse takes priority over traffic in the same cycle. That traffic
  // is dropped, so the sweep starts from an untouched snapshot.
  assign w_idle_go = (r_state == ST_IDLE) && !clr;
  assign w_wr_in   = ({1'b0, wr_addr} < DEPTH_X);
  assign w_rd_in   = ({1'b0, rd_addr} < DEPTH_X);
  assign w_wr_ok   = w_idle_go && we && w_wr_in;
  // Out-of-range reads are still accepted; they simply return zero.
  assign w_rd_ok   = w_idle_go && re;
  assign w_clr_wr  = (r_state == ST_CLEAR) && !rst;

  // -------------------------------------------------------------------------
  // Control FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (clr) begin
          w_state_nxt = ST_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        // clr is ignored here; an ongoing sweep is never restarted by it.
        if (r_ptr == LAST_PTR) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt   = r_ptr + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  assign busy = (r_state == ST_CLEAR);

  // -------------------------------------------------------------------------
  // Storage array: the sweep and normal writes share the one write port
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_clr_wr) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= f_merge(r_mem[wr_addr], wr_data, wr_be);
    end
  end

  // Read word as it will be captured at the accepting edge. The array
  // read sees the pre-write contents, which gives read-first behaviour.
  always_comb begin
    w_rd_word = w_rd_in ? r_mem[rd_addr] : '0;
`ifdef SYN_RAM_PARAM_BYPASS_EN
    if (w_wr_ok && (wr_addr == rd_addr)) begin
      w_rd_word = f_merge(w_rd_word, wr_data, wr_be);
    end
`endif
  end

  // -------------------------------------------------------------------------
  // Read stage p0: array output register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p0     <= 1'b0;
      r_rd_data_p0 <= '0;
    end else begin
      r_vld_p0 <= w_rd_ok;
      if (w_rd_ok) begin
        r_rd_data_p0 <= w_rd_word;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              r_vld_p1;
      logic [DATA_W-1:0] r_rd_data_p1;

      // ---------------------------------------------------------------------
      // Read stage p1: optional output register
      // ---------------------------------------------------------------------
      always_ff @(posedge clk) begin
        if (rst) begin
          r_vld_p1     <= 1'b0;
          r_rd_data_p1 <= '0;
        end else begin
          r_vld_p1 <= r_vld_p0;
          if (r_vld_p0) begin
            r_rd_data_p1 <= r_rd_data_p0;
          end
        end
      end

      assign rd_data  = r_rd_data_p1;
      assign rd_valid = r_vld_p1;
    end else begin : g_noreg
      assign rd_data  = r_rd_data_p0;
      assign rd_valid = r_vld_p0;
    end
  endgenerate

endmodule
